// File: rtl/apb_reg_bank.sv
// APB slave register bank: parametrised width and depth, byte-lane write
// strobes, programmable wait states and an error response for addresses
// outside the bank.
module apb_reg_bank #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 24,
  parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH) + 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic                    wr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  input  logic                    sel,
  input  logic                    enable,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    slverr
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W     = 8;
  // Depth widened by one bit so the range compare never truncates.
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];

  logic                    in_range;
  logic [IDX_W-1:0]        idx;
  logic                    in_access;
  logic                    commit_wr;

  // Address decode shared by the read path and the write path.
  always_comb begin
    in_range  = ({1'b0, addr} < DEPTH_A);
    idx       = IDX_W'(addr);
    in_access = (state_q == S_ACCESS);
    commit_wr = in_access && sel && enable && wr && in_range;
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (sel) begin
          if (WAIT_STATES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (!sel) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACCESS: begin
        // Holding sel with enable low keeps the bank in ACCESS.
        if (!sel || enable) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Byte-lane merge of write data into the addressed register.
  always_comb begin
    mem_d = mem_q;
    if (commit_wr) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (strb[i]) begin
          mem_d[idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end
  end

  // Response outputs decoded from the current state and the live inputs.
  always_comb begin
    ready  = in_access;
    slverr = in_access && !in_range;
    rdata  = '0;
    if (in_access && !wr && in_range) begin
      rdata = mem_q[idx];
    end
  end

  // State, counter and register storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_bank.sv
// Testbench for apb_reg_bank: three instances with 0, 2 and 3 wait states
// share all inputs except sel, so each transfer targets exactly one bank.
module tb_apb_reg_bank;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEP   = 24;
  localparam int unsigned AW    = 5;
  localparam logic [31:0] RV    = 32'hA5A5A5A5;
  localparam int          TMO   = 300;

  logic          clk;
  logic          reset;
  logic [AW-1:0] addr;
  logic          wr;
  logic [DW-1:0] wdata;
  logic [3:0]    strb;
  logic [2:0]    sel_v;
  logic          enable;
  logic [2:0]    ready_v;
  logic [2:0]    slverr_v;
  logic [DW-1:0] rdata_v [3];

  int checks;
  int errors;

  // Instance 0: no wait states.
  apb_reg_bank #(.DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW), .RESET_VAL(RV), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .reset(reset), .addr(addr), .wr(wr), .wdata(wdata), .strb(strb),
    .sel(sel_v[0]), .enable(enable), .ready(ready_v[0]), .rdata(rdata_v[0]), .slverr(slverr_v[0]));

  // Instance 1: two wait states.
  apb_reg_bank #(.DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW), .RESET_VAL(RV), .WAIT_STATES(2)) u_w2 (
    .clk(clk), .reset(reset), .addr(addr), .wr(wr), .wdata(wdata), .strb(strb),
    .sel(sel_v[1]), .enable(enable), .ready(ready_v[1]), .rdata(rdata_v[1]), .slverr(slverr_v[1]));

  // Instance 2: three wait states.
  apb_reg_bank #(.DATA_WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW), .RESET_VAL(RV), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .reset(reset), .addr(addr), .wr(wr), .wdata(wdata), .strb(strb),
    .sel(sel_v[2]), .enable(enable), .ready(ready_v[2]), .rdata(rdata_v[2]), .slverr(slverr_v[2]));

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transfer starting from the cycle in which this is called
  // (caller sits #1 after a rising edge); returns on the same phase after
  // the completion edge so calls can run back to back.
  task automatic xfer(input int d, input logic w, input logic [4:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er, output int cyc);
    int n;
    rd  = '0;
    er  = 1'b0;
    cyc = 0;
    sel_v    = '0;
    sel_v[d] = 1'b1;
    addr     = a;
    wr       = w;
    wdata    = wd;
    strb     = st;
    enable   = 1'b0;
    n        = 1;
    @(negedge clk);
    chk("setup_ready_low", 32'(ready_v[d]), 32'd0);
    @(posedge clk);
    #1;
    enable = 1'b1;
    for (int k = 0; k < TMO; k++) begin
      n++;
      @(negedge clk);
      if (ready_v[d]) begin
        rd  = rdata_v[d];
        er  = slverr_v[d];
        cyc = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (cyc == 0) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout: dut %0d addr %0d no ready after %0d cycles", d, a, TMO);
    end
    @(posedge clk);
    #1;
    sel_v  = '0;
    enable = 1'b0;
  endtask

  vec_t        vecs [14];
  logic [31:0] rd;
  logic        er;
  int          cyc;
  logic [31:0] exp_v;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    addr   = '0;
    wr     = 1'b0;
    wdata  = '0;
    strb   = '0;
    sel_v  = '0;
    enable = 1'b0;

    vecs[0]  = '{0, 1'b1, 5'd5,  32'h11223344, 4'b1111, 32'h00000000, 1'b0, 2};
    vecs[1]  = '{0, 1'b1, 5'd5,  32'hFFEEDDCC, 4'b0101, 32'h00000000, 1'b0, 2};
    vecs[2]  = '{0, 1'b0, 5'd5,  32'h00000000, 4'b0000, 32'h11EE33CC, 1'b0, 2};
    vecs[3]  = '{0, 1'b1, 5'd24, 32'hDEADBEEF, 4'b1111, 32'h00000000, 1'b1, 2};
    vecs[4]  = '{0, 1'b0, 5'd24, 32'h00000000, 4'b1111, 32'h00000000, 1'b1, 2};
    vecs[5]  = '{0, 1'b0, 5'd31, 32'h00000000, 4'b0000, 32'h00000000, 1'b1, 2};
    vecs[6]  = '{0, 1'b1, 5'd6,  32'h12345678, 4'b0000, 32'h00000000, 1'b0, 2};
    vecs[7]  = '{0, 1'b0, 5'd6,  32'h00000000, 4'b1111, 32'hA5A5A5A5, 1'b0, 2};
    vecs[8]  = '{0, 1'b1, 5'd23, 32'hCAFEF00D, 4'b1000, 32'h00000000, 1'b0, 2};
    vecs[9]  = '{0, 1'b0, 5'd23, 32'h00000000, 4'b0000, 32'hCAA5A5A5, 1'b0, 2};
    vecs[10] = '{2, 1'b0, 5'd2,  32'h00000000, 4'b0000, 32'hA5A5A5A5, 1'b0, 5};
    vecs[11] = '{2, 1'b0, 5'd2,  32'h00000000, 4'b0000, 32'hA5A5A5A5, 1'b0, 5};
    vecs[12] = '{1, 1'b1, 5'd10, 32'h0F0F0F0F, 4'b0011, 32'h00000000, 1'b0, 4};
    vecs[13] = '{1, 1'b0, 5'd10, 32'h00000000, 4'b0000, 32'hA5A50F0F, 1'b0, 4};

    // Reset state: outputs low while reset is held.
    #1 reset = 1'b1;
    #2;
    for (int d = 0; d < 3; d++) begin
      chk("reset_ready", 32'(ready_v[d]), 32'd0);
      chk("reset_rdata", rdata_v[d], 32'd0);
      chk("reset_slverr", 32'(slverr_v[d]), 32'd0);
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Every register reads the reset value with two-cycle latency.
    for (int a = 0; a < DEP; a++) begin
      xfer(0, 1'b0, 5'(a), 32'h0, 4'h0, rd, er, cyc);
      chk("sweep0_rdata", rd, RV);
      chk("sweep0_slverr", 32'(er), 32'd0);
      chk("sweep0_cycles", 32'(cyc), 32'd2);
    end

    // Directed vector table, applied back to back.
    for (int i = 0; i < 14; i++) begin
      xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, cyc);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_slverr", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
    end

    // Sweep after the table: only addr 5 and 23 were legally written.
    for (int a = 0; a < DEP; a++) begin
      if (a == 5)       exp_v = 32'h11EE33CC;
      else if (a == 23) exp_v = 32'hCAA5A5A5;
      else              exp_v = RV;
      xfer(0, 1'b0, 5'(a), 32'h0, 4'h0, rd, er, cyc);
      chk($sformatf("sweep1_a%0d", a), rd, exp_v);
    end

    // ACCESS held with enable low: ready stays high, nothing commits.
    sel_v = 3'b001; wr = 1'b1; addr = 5'd8; wdata = 32'h00000077; strb = 4'hF; enable = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("hold_ready", 32'(ready_v[0]), 32'd1);
      chk("hold_rdata", rdata_v[0], 32'd0);
      @(posedge clk);
      #1;
    end
    sel_v = '0;
    @(posedge clk);
    #1;
    xfer(0, 1'b0, 5'd8, 32'h0, 4'h0, rd, er, cyc);
    chk("hold_addr8", rd, RV);

    // Abort during WAIT on the two-wait-state bank.
    sel_v = 3'b010; wr = 1'b1; addr = 5'd3; wdata = 32'h55555555; strb = 4'hF; enable = 1'b0;
    @(posedge clk);
    #1 enable = 1'b1;
    @(negedge clk);
    chk("abort_wait_ready", 32'(ready_v[1]), 32'd0);
    @(posedge clk);
    #1;
    sel_v  = '0;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_idle_ready", 32'(ready_v[1]), 32'd0);
      @(posedge clk);
      #1;
    end
    xfer(1, 1'b0, 5'd3, 32'h0, 4'h0, rd, er, cyc);
    chk("abort_addr3", rd, RV);
    chk("abort_next_cycles", 32'(cyc), 32'd4);

    // Reset asserted during ACCESS of a write to addr 7.
    sel_v = 3'b001; wr = 1'b1; addr = 5'd7; wdata = 32'h00000001; strb = 4'hF; enable = 1'b0;
    @(posedge clk);
    #1 enable = 1'b1;
    @(negedge clk);
    chk("rst_pre_ready", 32'(ready_v[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_ready", 32'(ready_v[0]), 32'd0);
    chk("rst_async_rdata", rdata_v[0], 32'd0);
    chk("rst_async_slverr", 32'(slverr_v[0]), 32'd0);
    sel_v  = '0;
    enable = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    xfer(0, 1'b0, 5'd7, 32'h0, 4'h0, rd, er, cyc);
    chk("rst_addr7", rd, RV);
    chk("rst_idle_cycles", 32'(cyc), 32'd2);
    xfer(0, 1'b0, 5'd5, 32'h0, 4'h0, rd, er, cyc);
    chk("rst_addr5", rd, RV);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
